// File: rtl/seg7_if.sv
// seg7_if: CPU-side write port and scanner-side segment bus of the seven-segment formatter
interface seg7_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        dec_mode;
    logic [7:0]  dp_mask;
    logic        busy;
    logic [63:0] numbers;
    modport master (output wr_en, wr_data, dec_mode, dp_mask, input busy, numbers);
    modport slave  (input wr_en, wr_data, dec_mode, dp_mask, output busy, numbers);
endinterface

// File: rtl/seg7_formatter.sv
// seg7_formatter: 32-bit value to eight seven-segment bytes, hex or double-dabble decimal; SEG7_LZB_EN enables leading-zero blanking
module seg7_formatter (
    input  logic  clk,
    input  logic  rst_n,
    seg7_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, ENCODE} state_t;
`ifdef SEG7_LZB_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    state_t      r_state, w_next;
    logic        r_busy, r_dec, w_accept, w_ovf;
    logic [7:0]  r_dp;
    logic [4:0]  r_cnt;
    logic [39:0] r_bcd, w_bcd_adj;
    logic [31:0] r_bin, w_digits;
    logic [63:0] r_numbers, w_enc;
    assign w_accept    = (r_state == IDLE) && bus.wr_en;
    assign bus.busy    = r_busy;
    assign bus.numbers = r_numbers;
    // next state: writes only start from IDLE, CONV runs 32 cycles, ENCODE is a single cycle
    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = bus.dec_mode ? CONV : ENCODE;
        else if (r_state == CONV && r_cnt == 5'd31)
            w_next = ENCODE;
        else if (r_state == ENCODE)
            w_next = IDLE;
    end
    // state register; busy is decoded from the next state so it is a clean flop output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
        end
    end
    // double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 10; i++)
            w_bcd_adj[4*i+:4] = (r_bcd[4*i+:4] >= 4'd5) ? r_bcd[4*i+:4] + 4'd3 : r_bcd[4*i+:4];
    end
    // glyph lookup per digit; overflow dashes skip blanking, dp is ORed in last
    always_comb begin
        logic seen;
        seen     = 1'b0;
        w_enc    = '0;
        w_digits = r_dec ? r_bcd[31:0] : r_bin;
        w_ovf    = r_dec && (r_bcd[39:32] != 8'd0);
        for (int i = 7; i >= 0; i--) begin
            seen = seen | (w_digits[4*i+:4] != 4'd0);
            w_enc[8*i+:8] = {r_dp[i], w_ovf ? 7'h40 : (LZB && !seen && i != 0) ? 7'h00 : GLYPH[w_digits[4*i+:4]]};
        end
    end
    // datapath: latch on accept, shift during CONV, publish the whole display at once in ENCODE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dec     <= 1'b0;
            r_dp      <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_numbers <= '0;
        end else if (w_accept) begin
            r_bin <= bus.wr_data;
            r_dec <= bus.dec_mode;
            r_dp  <= bus.dp_mask;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == CONV) begin
            {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
            r_cnt          <= r_cnt + 5'd1;
        end else if (r_state == ENCODE) begin
            r_numbers <= w_enc;
        end
    end
endmodule

// File: tb/tb_seg7_formatter.sv
// tb_seg7_formatter: directed vectors for seg7_formatter; expectations follow SEG7_LZB_EN
module tb_seg7_formatter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    seg7_if bus ();
    seg7_formatter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef SEG7_LZB_EN
    localparam logic [63:0] EXP_A5 = 64'h00000000000077ED;
    localparam logic [63:0] EXP_Z  = 64'h000000000000003F;
    localparam logic [63:0] EXP_7  = 64'h0000000000000007;
`else
    localparam logic [63:0] EXP_A5 = 64'h3F3F3F3F3F3F77ED;
    localparam logic [63:0] EXP_Z  = 64'h3F3F3F3F3F3F3F3F;
    localparam logic [63:0] EXP_7  = 64'h3F3F3F3F3F3F3F07;
`endif
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic do_write(input string tag, input logic [31:0] d, input logic dm, input logic [7:0] dp);
        logic [63:0] prev;
        @(negedge clk);
        prev         = bus.numbers;
        bus.wr_en    = 1'b1;
        bus.wr_data  = d;
        bus.dec_mode = dm;
        bus.dp_mask  = dp;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
        check({tag, "_hold"}, bus.numbers, prev);
    endtask
    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check({tag, "_timeout"}, 64'(bus.busy), 64'd0);
    endtask
    task automatic run(input string tag, input logic [31:0] d, input logic dm, input logic [7:0] dp,
                       input int exp_busy, input logic [63:0] exp_num);
        int n;
        do_write(tag, d, dm, dp);
        wait_idle(tag, n);
        check({tag, "_busy_len"}, 64'(n), 64'(exp_busy));
        check({tag, "_num"}, bus.numbers, exp_num);
    endtask
    initial begin
        int n;
        rst_n        = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.dec_mode = 1'b0;
        bus.dp_mask  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_num", bus.numbers, 64'd0);
        rst_n = 1'b1;
        run("hex_1234abcd", 32'h1234ABCD, 1'b0, 8'h00, 1, 64'h065B4F66777C395E);
        run("dec_12345678", 32'd12345678, 1'b1, 8'h00, 33, 64'h065B4F666D7D077F);
        run("dec_ovf", 32'd100000000, 1'b1, 8'h00, 33, 64'h4040404040404040);
        run("dec_ovf_dp", 32'hFFFFFFFF, 1'b1, 8'h80, 33, 64'hC040404040404040);
        run("dec_max", 32'd99999999, 1'b1, 8'h00, 33, 64'h6F6F6F6F6F6F6F6F);
        run("hex_a5_dp", 32'h000000A5, 1'b0, 8'h01, 1, EXP_A5);
        run("hex_zero", 32'h0, 1'b0, 8'h00, 1, EXP_Z);
        run("dec_seven", 32'd7, 1'b1, 8'h00, 33, EXP_7);
        run("dec_zero", 32'd0, 1'b1, 8'h00, 33, EXP_Z);
        do_write("ign", 32'd12345678, 1'b1, 8'h00);
        repeat (9) @(negedge clk);
        bus.wr_en    = 1'b1;
        bus.wr_data  = 32'hFFFFFFFF;
        bus.dec_mode = 1'b0;
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_idle("ign", n);
        check("ign_busy_len", 64'(n), 64'd23);
        check("ign_num", bus.numbers, 64'h065B4F666D7D077F);
        do_write("rst_mid", 32'd87654321, 1'b1, 8'h00);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_num", bus.numbers, 64'd0);
        rst_n = 1'b1;
        run("hex_after_rst", 32'hCAFE0001, 1'b0, 8'hF0, 1, 64'hB9F7F1F93F3F3F06);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.wr_en    = 1'b1;
        bus.wr_data  = 32'h12345678;
        bus.dec_mode = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.wr_en = 1'b0;
        check("rst_wr_busy", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk);
        check("rst_wr_num", bus.numbers, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
